// File: rtl/mips_mc_pkg.sv
// Shared constants for the multi-cycle 16-bit-instruction MIPS core:
// opcodes, FSM state codes and the immediate sign-extension helper.
package mips_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_SW   = 4'h4;
    localparam logic [3:0] OP_JUMP = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    // Sign-extend the 4-bit immediate field; callers cast down to their width.
    function automatic logic [63:0] sign_ext4(input logic [3:0] imm);
        return {{60{imm[3]}}, imm};
    endfunction

endpackage

// File: rtl/mips_alu_param.sv
// Combinational ALU. ADDI, LW and SW share the adder with ADD (address
// generation is R[B]+imm); any other opcode also falls through to the adder.
module mips_alu_param
    import mips_mc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Select the ALU function from the opcode.
    always_comb begin
        // NOTE: every path assigns y (default arm below), so no latch is inferred.
        case (op)
            OP_SUB:  y = a - b;
            OP_XOR:  y = a ^ b;
            OP_OR:   y = a | b;
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB sequencing, register file,
// program-loadable instruction memory and data memory, with run/halt handshake
// and a combinational register debug port.
module mips_multicycle_core
    import mips_mc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int IMEM_AW = 4,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [15:0]        prog_data,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [IMEM_AW-1:0] pc,
    output logic [2:0]         state,
    output logic [DATA_W-1:0]  alu_out,
    output logic               instr_done,
    output logic               halted
);

    logic [15:0]        imem [2**IMEM_AW];
    logic [DATA_W-1:0]  dmem [2**DMEM_AW];
    logic [DATA_W-1:0]  regs [2**REG_AW];

    logic [15:0]        ir;
    logic [DATA_W-1:0]  a_q, b_q, c_q, imm_q, load_q;
    logic [DATA_W-1:0]  alu_b, alu_y;

    logic [3:0]         op;
    logic [REG_AW-1:0]  ra, rb, rc;
    logic [IMEM_AW-1:0] pc_inc;
    logic               is_alu, is_mem;
    logic [DMEM_AW-1:0] mem_addr;

    assign op       = ir[15:12];
    assign ra       = ir[8 +: REG_AW];
    assign rb       = ir[4 +: REG_AW];
    assign rc       = ir[0 +: REG_AW];
    assign pc_inc   = pc + IMEM_AW'(1);
    assign is_alu   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) ||
                      (op == OP_XOR) || (op == OP_OR);
    assign is_mem   = (op == OP_LW) || (op == OP_SW);
    assign mem_addr = alu_out[DMEM_AW-1:0];

    // Register-register ops take R[C]; ADDI/LW/SW take the immediate.
    assign alu_b    = (is_alu && op != OP_ADDI) ? c_q : imm_q;
    assign dbg_data = (dbg_sel == '0) ? '0 : regs[dbg_sel];

    mips_alu_param #(.DATA_W(DATA_W)) u_alu (
        .op (op),
        .a  (b_q),
        .b  (alu_b),
        .y  (alu_y)
    );

    // Flag the last cycle of each instruction class.
    always_comb begin
        instr_done = 1'b0;
        case (state)
            S_DECODE: instr_done = (op == OP_HALT);
            S_EXEC:   instr_done = !(is_alu || is_mem);
            S_MEM:    instr_done = (op == OP_SW);
            S_WB:     instr_done = 1'b1;
            default:  instr_done = 1'b0;
        endcase
    end

    // Memory writes; contents survive reset, and reset still blocks a pending write.
    always_ff @(posedge clk) begin
        // NOTE: memories have no reset term so they map onto RAM; only the
        // write enables are qualified by rst.
        if (!rst && state == S_IDLE && prog_we)
            imem[prog_addr] <= prog_data;
        if (!rst && state == S_MEM && op == OP_SW)
            dmem[mem_addr] <= a_q;
    end

    // Main FSM, datapath registers and register-file writeback.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            alu_out <= '0;
            halted  <= 1'b0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            imm_q   <= '0;
            load_q  <= '0;
            for (int i = 0; i < 2**REG_AW; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A program write in the same cycle wins over starting.
                    if (run && !prog_we) begin
                        state  <= S_FETCH;
                        halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= imem[pc];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a_q   <= (ra == '0) ? '0 : regs[ra];
                    b_q   <= (rb == '0) ? '0 : regs[rb];
                    c_q   <= (rc == '0) ? '0 : regs[rc];
                    imm_q <= DATA_W'(sign_ext4(ir[3:0]));
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        pc     <= pc_inc;
                        state  <= S_IDLE;
                    end else begin
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_alu || is_mem) begin
                        alu_out <= alu_y;
                        state   <= is_mem ? S_MEM : S_WB;
                    end else begin
                        if (op == OP_JUMP)
                            pc <= ir[IMEM_AW-1:0];
                        else if (op == OP_BEQ && a_q == b_q)
                            pc <= pc_inc + IMEM_AW'(sign_ext4(ir[3:0]));
                        else
                            pc <= pc_inc;
                        state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (op == OP_LW) begin
                        load_q <= dmem[mem_addr];
                        state  <= S_WB;
                    end else begin
                        pc    <= pc_inc;
                        state <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (ra != '0)
                        regs[ra] <= (op == OP_LW) ? load_q : alu_out;
                    pc    <= pc_inc;
                    state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
